// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// channel and the {pc, inst} handshake toward decode.
interface if_fetch_stage_if #(
    parameter int XLEN = 64
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_inst;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_inst;

    // Fetch stage side
    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_inst,
        output id_valid, id_pc, id_inst,
        input  id_ready
    );

    // Memory / decode / branch-resolution side
    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_inst,
        input  id_valid, id_pc, id_inst,
        output id_ready
    );
endinterface

// File: rtl/if_fetch_stage.sv
// RV64I fetch stage: owns the PC, issues one word fetch at a time and buffers
// returned instructions in a 2-entry FIFO ahead of decode.
module if_fetch_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input logic              clk,
    input logic              rst,
    if_fetch_stage_if.master fetch
);
    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            outstanding;
    logic            drop;
    logic [1:0]      count;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [XLEN-1:0] fifo_pc   [2];
    logic [31:0]     fifo_inst [2];

    logic req_fire;
    logic push;
    logic pop;

    // A redirect masks both the new request and the decode handshake in its cycle.
    assign fetch.imem_req_valid = ~rst & (state == S_REQ) & ~outstanding &
                                  (count != 2'd2) & ~fetch.redirect_valid;
    assign fetch.imem_req_addr  = pc;
    assign req_fire             = fetch.imem_req_valid & fetch.imem_req_ready;

    assign push = (state == S_WAIT) & fetch.imem_resp_valid & ~drop & ~fetch.redirect_valid;

    assign fetch.id_valid = ~rst & (count != 2'd0) & ~fetch.redirect_valid;
    assign fetch.id_pc    = rst ? '0 : fifo_pc[rd_ptr];
    assign fetch.id_inst  = rst ? '0 : fifo_inst[rd_ptr];
    assign pop            = fetch.id_valid & fetch.id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
        end else if (fetch.redirect_valid) begin
            pc     <= fetch.redirect_pc & ~XLEN'(3);
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            // The single in-flight response either lands now (discard) or later (drop it then).
            if (state == S_WAIT) begin
                if (fetch.imem_resp_valid) begin
                    state       <= S_REQ;
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                end else begin
                    drop <= 1'b1;
                end
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        pc          <= pc + XLEN'(4);
                        outstanding <= 1'b1;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fetch.imem_resp_valid) begin
                        outstanding <= 1'b0;
                        drop        <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Datapath registers carry no reset; the FIFO count qualifies their contents.
    always_ff @(posedge clk) begin
        if (req_fire) req_pc <= pc;
        if (push) begin
            fifo_pc[wr_ptr]   <= req_pc;
            fifo_inst[wr_ptr] <= fetch.imem_resp_inst;
        end
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- RV64I instruction fetch stage, directly upstream of the decode stage.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers returned instructions in a 2-entry FIFO and presents {pc, inst} to decode over a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution, which flush the FIFO and discard any in-flight response.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- XLEN, 64, PC/address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  replace the fetch PC this cycle.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored and treated as 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_resp_valid  in  1  one-cycle pulse carrying the instruction; exactly one per accepted request, at least 1 cycle after acceptance; cannot be stalled.
- imem_resp_inst  in  32  returned instruction word.
- id_valid  out  1  FIFO head valid toward decode.
- id_ready  in  1  decode consumes the head.
- id_pc  out  XLEN  PC of the head instruction.
- id_inst  out  32  head instruction word.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc <= RESET_PC, fifo count <= 0, outstanding <= 0, drop <= 0, state <= REQ.
  - While rst is high: imem_req_valid=0, id_valid=0, id_pc=0, id_inst=0.
  - The memory shares rst, so no pre-reset response arrives after reset; reset mid-transaction simply abandons it.
- Registers:
  - pc: next address to request.
  - req_pc: address of the in-flight request.
  - outstanding flag (at most 1 request in flight).
  - drop flag.
  - 2-entry FIFO of {pc, inst} with count 0..2, read pointer and write pointer (1 bit each, wrapping).
- State machine, 2 states:
  - REQ:
    - imem_req_valid = (count<2) & ~redirect_valid; imem_req_addr = pc.
    - On handshake: req_pc <= pc, pc <= pc+4 (64-bit modular wrap, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0), go to WAIT.
  - WAIT:
    - imem_req_valid=0.
    - On imem_resp_valid with drop=0: push {req_pc, imem_resp_inst}, go to REQ.
    - On imem_resp_valid with drop=1: discard the word, clear drop, go to REQ.
- FIFO never overflows: a request is only issued when count<2 and nothing is outstanding.
- Decode side:
  - id_valid = (count!=0) & ~redirect_valid & ~rst.
  - Pop on id_valid & id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - id_pc/id_inst come combinationally from the head entry; hold stable while id_valid & ~id_ready.
- Redirect (highest priority, takes effect at the clock edge):
  - count <= 0 and pointers reset; no pop occurs that cycle, since id_valid is masked.
  - pc <= {redirect_pc[63:2], 2'b00}.
  - In WAIT without a response this cycle: drop <= 1, state stays WAIT.
  - In WAIT with a response this cycle: the response is discarded, drop <= 0, go to REQ.
  - In REQ: no request is issued this cycle (masked), state stays REQ.
- Back-to-back redirects: the last one wins; drop stays set until the single outstanding response returns.
- Latency:
  - First cycle after rst falls: imem_req_valid=1 with addr=RESET_PC.
  - With an always-ready, 1-cycle memory, id_valid rises 2 cycles after the request handshake.
  - Peak throughput is 1 instruction per 2 cycles.
- imem_resp_valid while in REQ is a protocol violation: ignore it, and the bench asserts on it.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning 32'h0000_0013, id_ready=1 -> requests at 8000_0000, 8000_0004, 8000_0008; decode sees matching id_pc and inst 0x13 in order, one every 2 cycles.
- id_ready=0 for 10 cycles -> exactly 2 entries (pcs 8000_0000, 8000_0004) buffered, no third request; id_ready=1 -> both drained in order, then fetching resumes at 8000_0008.
- Redirect to 64'h8000_0103 while a request is outstanding (memory latency 3) -> that response is dropped; next request addr = 8000_0100; id_valid stays low until the 8000_0100 instruction arrives.
- Redirect in the same cycle as a response, with FIFO holding 1 entry -> both the entry and the response are discarded; id_valid=0 next cycle; next request at the redirect target.
- imem_req_ready held low 5 cycles -> imem_req_valid and imem_req_addr held stable; pc does not advance.
- pc = 64'hFFFF_FFFF_FFFF_FFFC fetched -> next request addr = 0; rst asserted mid-WAIT -> next cycle outputs return to reset values, and the first request after reset is at RESET_PC.
